// File: rtl/stopwatch_tick_counter.sv
// rtl/stopwatch_tick_counter.sv - MM:SS BCD stopwatch counting synchronized slow-clock ticks
//
// Purpose:
//   Samples the divided slow-clock level as data on the system clock, turns each
//   rising edge into a one-cycle tick and counts ticks as an MM:SS BCD stopwatch
//   under start/stop and clear control. Digits feed the seven-segment driver.
//
// Optional feature macro: STOPWATCH_LAP_EN (adds lap_in / lap_active display freeze).
//
// Ports:
//   clock_in       in   system clock, all logic on its rising edge
//   reset          in   asynchronous active-high reset
//   slow_clk_in    in   divided slow-clock level, treated as asynchronous data
//   start_stop_in  in   start/stop button level, acts on rising edge
//   clear_in       in   clear button level, acts on rising edge
//   lap_in         in   (STOPWATCH_LAP_EN) lap button level, acts on rising edge
//   lap_active     out  (STOPWATCH_LAP_EN) high while the display is frozen
//   sec_ones       out  BCD seconds units
//   sec_tens       out  BCD seconds tens
//   min_ones       out  BCD minutes units
//   min_tens       out  BCD minutes tens, 0..MIN_TENS_MAX
//   running        out  high while in RUN
//   rollover       out  one-cycle pulse on wrap from max time to 00:00

module stopwatch_tick_counter #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       slow_clk_in,
  input  logic       start_stop_in,
  input  logic       clear_in,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_in,
  output logic       lap_active,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover
);

  localparam logic [3:0] MT_MAX = MIN_TENS_MAX[3:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   ss_prev_q;
  logic                   clr_prev_q;
  logic [3:0]             so_q, st_q, mo_q, mt_q;
  logic [3:0]             so_d, st_d, mo_d, mt_d;
  logic                   running_q, running_d;
  logic                   rollover_q, rollover_d;

  logic synced;
  logic tick;
  logic ss_edge;
  logic clr_edge;
  logic inc;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign tick     = synced & ~hist_q;
  assign ss_edge  = start_stop_in & ~ss_prev_q;
  assign clr_edge = clear_in & ~clr_prev_q;
  // Counting uses the pre-transition state, so a tick landing on RUN->PAUSE
  // still counts while one landing on IDLE/PAUSE->RUN does not.
  assign inc      = tick & (state_q == RUN) & ~clr_edge;

  // Input synchronizer, history flop and button edge detectors.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
      hist_q     <= synced;
      ss_prev_q  <= start_stop_in;
      clr_prev_q <= clear_in;
    end
  end

  // State register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
    end
  end

  // Next-state logic; clear wins over start/stop in the same cycle.
  always_comb begin
    state_d = state_q;
    if (clr_edge) begin
      state_d = IDLE;
    end else if (ss_edge) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  // BCD ripple-carry increment across all four digits in one cycle.
  always_comb begin
    so_d       = so_q;
    st_d       = st_q;
    mo_d       = mo_q;
    mt_d       = mt_q;
    rollover_d = 1'b0;
    if (clr_edge) begin
      so_d = 4'd0;
      st_d = 4'd0;
      mo_d = 4'd0;
      mt_d = 4'd0;
    end else if (inc) begin
      if (so_q >= 4'd9) begin
        so_d = 4'd0;
        if (st_q >= 4'd5) begin
          st_d = 4'd0;
          if (mo_q >= 4'd9) begin
            mo_d = 4'd0;
            if (mt_q >= MT_MAX) begin
              mt_d       = 4'd0;
              rollover_d = 1'b1;
            end else begin
              mt_d = mt_q + 4'd1;
            end
          end else begin
            mo_d = mo_q + 4'd1;
          end
        end else begin
          st_d = st_q + 4'd1;
        end
      end else begin
        so_d = so_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      so_q       <= 4'd0;
      st_q       <= 4'd0;
      mo_q       <= 4'd0;
      mt_q       <= 4'd0;
      rollover_q <= 1'b0;
    end else begin
      so_q       <= so_d;
      st_q       <= st_d;
      mo_q       <= mo_d;
      mt_q       <= mt_d;
      rollover_q <= rollover_d;
    end
  end

  assign running  = running_q;
  assign rollover = rollover_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_prev_q;
  logic        lap_q, lap_d;
  logic [15:0] frz_q, frz_d;
  logic        lap_edge;

  assign lap_edge = lap_in & ~lap_prev_q;

  // Lap toggles only in RUN; the first edge snapshots the live digits.
  always_comb begin
    lap_d = lap_q;
    frz_d = frz_q;
    if (clr_edge) begin
      lap_d = 1'b0;
    end else if (lap_edge && (state_q == RUN)) begin
      lap_d = ~lap_q;
      if (!lap_q) begin
        frz_d = {mt_q, mo_q, st_q, so_q};
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lap_prev_q <= 1'b0;
      lap_q      <= 1'b0;
      frz_q      <= '0;
    end else begin
      lap_prev_q <= lap_in;
      lap_q      <= lap_d;
      frz_q      <= frz_d;
    end
  end

  assign lap_active = lap_q;
  assign {min_tens, min_ones, sec_tens, sec_ones} =
      lap_q ? frz_q : {mt_q, mo_q, st_q, so_q};
`else
  assign {min_tens, min_ones, sec_tens, sec_ones} = {mt_q, mo_q, st_q, so_q};
`endif

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// tb/tb_stopwatch_tick_counter.sv - directed self-checking bench for stopwatch_tick_counter

module tb_stopwatch_tick_counter;

  logic       clock_in;
  logic       reset;
  logic       slow_clk_in;
  logic       start_stop_in;
  logic       clear_in;
`ifdef STOPWATCH_LAP_EN
  logic       lap_in;
  logic       lap_active;
`endif
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, rollover;

  int checks = 0;
  int fails  = 0;

  stopwatch_tick_counter #(.SYNC_STAGES(2), .MIN_TENS_MAX(5)) dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .slow_clk_in   (slow_clk_in),
    .start_stop_in (start_stop_in),
    .clear_in      (clear_in),
`ifdef STOPWATCH_LAP_EN
    .lap_in        (lap_in),
    .lap_active    (lap_active),
`endif
    .sec_ones      (sec_ones),
    .sec_tens      (sec_tens),
    .min_ones      (min_ones),
    .min_tens      (min_tens),
    .running       (running),
    .rollover      (rollover)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // One slow-clock period: 3 cycles high, 3 low. Returns on a negedge after
  // the resulting count update has landed.
  task automatic slow_pulse();
    @(negedge clock_in) slow_clk_in = 1'b1;
    repeat (3) @(negedge clock_in);
    slow_clk_in = 1'b0;
    repeat (3) @(negedge clock_in);
  endtask

  task automatic press_ss();
    @(negedge clock_in) start_stop_in = 1'b1;
    @(negedge clock_in) start_stop_in = 1'b0;
  endtask

  task automatic press_clr();
    @(negedge clock_in) clear_in = 1'b1;
    @(negedge clock_in) clear_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clock_in);
    checks++;
    if (disp() !== 16'h0000) begin
      fails++;
      $display("FAIL reset_digits: got %h expected 0000", disp());
    end
    checks++;
    if (running !== 1'b0 || rollover !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: running=%b rollover=%b expected 0 0", running, rollover);
    end
    reset = 1'b0;
    repeat (3) slow_pulse();
    checks++;
    if (disp() !== 16'h0000 || running !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_count: got %h running=%b expected 0000 0", disp(), running);
    end
  endtask

  task automatic test_count12();
    press_ss();
    checks++;
    if (running !== 1'b1) begin
      fails++;
      $display("FAIL start_running: got %b expected 1", running);
    end
    // Latency: count visible after SYNC_STAGES+1 = 3 rising clock edges.
    @(negedge clock_in) slow_clk_in = 1'b1;
    @(negedge clock_in);
    checks++;
    if (sec_ones !== 4'd0) begin
      fails++;
      $display("FAIL tick_latency_1: got %0d expected 0", sec_ones);
    end
    @(negedge clock_in);
    checks++;
    if (sec_ones !== 4'd0) begin
      fails++;
      $display("FAIL tick_latency_2: got %0d expected 0", sec_ones);
    end
    @(negedge clock_in);
    checks++;
    if (sec_ones !== 4'd1) begin
      fails++;
      $display("FAIL tick_latency_3: got %0d expected 1", sec_ones);
    end
    slow_clk_in = 1'b0;
    repeat (3) @(negedge clock_in);
    checks++;
    if (sec_ones !== 4'd1) begin
      fails++;
      $display("FAIL falling_edge_no_tick: got %0d expected 1", sec_ones);
    end
    repeat (11) slow_pulse();
    checks++;
    if (disp() !== 16'h0012) begin
      fails++;
      $display("FAIL count_00_12: got %h expected 0012", disp());
    end
  endtask

  task automatic test_rollover();
    repeat (48) slow_pulse();
    checks++;
    if (disp() !== 16'h0100) begin
      fails++;
      $display("FAIL carry_01_00: got %h expected 0100", disp());
    end
    repeat (540) slow_pulse();
    checks++;
    if (disp() !== 16'h1000) begin
      fails++;
      $display("FAIL carry_10_00: got %h expected 1000", disp());
    end
    repeat (2998) slow_pulse();
    checks++;
    if (disp() !== 16'h5958) begin
      fails++;
      $display("FAIL preload_59_58: got %h expected 5958", disp());
    end
    slow_pulse();
    checks++;
    if (disp() !== 16'h5959 || rollover !== 1'b0) begin
      fails++;
      $display("FAIL at_59_59: got %h rollover=%b expected 5959 0", disp(), rollover);
    end
    begin
      int high_cycles;
      logic [15:0] at_roll;
      high_cycles = 0;
      at_roll = 16'hFFFF;
      @(negedge clock_in) slow_clk_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clock_in);
        if (i == 2) slow_clk_in = 1'b0;
        if (rollover === 1'b1) begin
          high_cycles++;
          at_roll = disp();
        end
      end
      checks++;
      if (high_cycles !== 1) begin
        fails++;
        $display("FAIL rollover_width: got %0d cycles expected 1", high_cycles);
      end
      checks++;
      if (at_roll !== 16'h0000) begin
        fails++;
        $display("FAIL rollover_digits: got %h expected 0000", at_roll);
      end
    end
  endtask

  task automatic test_clear_priority();
    repeat (3) slow_pulse();
    checks++;
    if (disp() !== 16'h0003 || running !== 1'b1) begin
      fails++;
      $display("FAIL pre_clear: got %h running=%b expected 0003 1", disp(), running);
    end
    @(negedge clock_in) begin
      start_stop_in = 1'b1;
      clear_in      = 1'b1;
    end
    @(negedge clock_in);
    checks++;
    if (disp() !== 16'h0000 || running !== 1'b0) begin
      fails++;
      $display("FAIL clear_priority: got %h running=%b expected 0000 0", disp(), running);
    end
    start_stop_in = 1'b0;
    clear_in      = 1'b0;
    slow_pulse();
    checks++;
    if (disp() !== 16'h0000 || running !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_clear: got %h running=%b expected 0000 0", disp(), running);
    end
  endtask

  task automatic test_pause_coincident();
    press_ss();
    repeat (7) slow_pulse();
    press_ss();
    checks++;
    if (running !== 1'b0 || disp() !== 16'h0007) begin
      fails++;
      $display("FAIL pause_state: got %h running=%b expected 0007 0", disp(), running);
    end
    slow_pulse();
    checks++;
    if (disp() !== 16'h0007) begin
      fails++;
      $display("FAIL pause_hold: got %h expected 0007", disp());
    end
    // Tick is high between the 2nd and 3rd rising edges; start/stop rises so
    // its edge is seen on that 3rd edge too.
    @(negedge clock_in) slow_clk_in = 1'b1;
    @(negedge clock_in);
    @(negedge clock_in) start_stop_in = 1'b1;
    @(negedge clock_in);
    checks++;
    if (running !== 1'b1 || disp() !== 16'h0007) begin
      fails++;
      $display("FAIL resume_coincident: got %h running=%b expected 0007 1", disp(), running);
    end
    start_stop_in = 1'b0;
    slow_clk_in   = 1'b0;
    repeat (3) @(negedge clock_in);
    slow_pulse();
    checks++;
    if (disp() !== 16'h0008) begin
      fails++;
      $display("FAIL after_resume: got %h expected 0008", disp());
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    press_clr();
    press_ss();
    repeat (3) slow_pulse();
    @(negedge clock_in) lap_in = 1'b1;
    @(negedge clock_in) lap_in = 1'b0;
    checks++;
    if (lap_active !== 1'b1 || disp() !== 16'h0003) begin
      fails++;
      $display("FAIL lap_freeze: got %h lap_active=%b expected 0003 1", disp(), lap_active);
    end
    repeat (4) slow_pulse();
    checks++;
    if (lap_active !== 1'b1 || disp() !== 16'h0003) begin
      fails++;
      $display("FAIL lap_hold: got %h lap_active=%b expected 0003 1", disp(), lap_active);
    end
    @(negedge clock_in) lap_in = 1'b1;
    @(negedge clock_in) lap_in = 1'b0;
    checks++;
    if (lap_active !== 1'b0 || disp() !== 16'h0007) begin
      fails++;
      $display("FAIL lap_release: got %h lap_active=%b expected 0007 0", disp(), lap_active);
    end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    slow_clk_in   = 1'b0;
    start_stop_in = 1'b0;
    clear_in      = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_in        = 1'b0;
`endif
    test_reset();
    test_count12();
    test_rollover();
    test_clear_priority();
    test_pause_coincident();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
